regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//   Parametrised register file with a per-register pending-write scoreboard for the decode stage.
//   Replaces the fixed 2-read/1-write, negedge-write register file with the following:
//   - posedge writes, synchronous reset and a configurable read-port count;
//   - a saturating pending-write counter per register;
//   - a decode stall output for RAW hazards on results still in flight.
// PARAMETERS
//   XLEN        32  data width of each register
//   NUM_REGS    32  register count; ADDR_W = $clog2(NUM_REGS) (localparam); register 0 hardwired to 0
//   NUM_R_PORTS 2   number of combinational read ports
//   PEND_W      2   width of each pending counter; max outstanding writes per reg = 2**PEND_W-1
// PORTS
//   CLK          in   1                   clock; all state updates on rising edge
//   RST          in   1                   reset, synchronous, active-high
//   REG_R_Addr   in   NUM_R_PORTS*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
//   REG_R_Used   in   NUM_R_PORTS         port p operand actually consumed by instr in decode
//   REG_R_Data   out  NUM_R_PORTS*XLEN    read data, port p at [p*XLEN +: XLEN]
//   REG_R_Busy   out  NUM_R_PORTS         port p register has a pending write
//   Stall_D      out  1                   OR over p of (REG_R_Used[p] & REG_R_Busy[p])
//   Issue_En     in   1                   instr leaving decode will write Issue_RD
//   Issue_RD     in   ADDR_W              destination of issuing instr
//   Issue_Ready  out  1                   pend[Issue_RD] below max (or Issue_RD==0)
//   REG_W_En     in   1                   writeback valid
//   REG_W_Addr   in   ADDR_W              writeback destination
//   REG_W_Data   in   XLEN                writeback data
//   Flush_En     in   1                   squash: clear all pending counters
// BEHAVIOUR
//   - Clock and reset: one clock (CLK); reset RST is synchronous and active-high.
//   - Reset: RST=1 at posedge zeroes every register and every pending counter; RST beats all other inputs that cycle.
//     Outputs after reset: REG_R_Data=0, REG_R_Busy=0, Stall_D=0, Issue_Ready=1.
//   - Write: if REG_W_En and REG_W_Addr!=0, regs[REG_W_Addr] <= REG_W_Data at posedge.
//     Writes to addr 0 are dropped; reads of addr 0 always return 0 and Busy=0.
//   - Pending counters pend[r], 0..2**PEND_W-1, updated at posedge:
//     - +1 on valid issue (Issue_En & Issue_Ready & Issue_RD==r & r!=0).
//     - -1 on writeback (REG_W_En & REG_W_Addr==r), saturating at 0: a writeback to a non-pending reg writes data and leaves pend at 0.
//     - Issue and writeback to the same r in one cycle: pend unchanged.
//     - Flush_En=1: all pend <= 0. Issue in the same cycle is ignored; a writeback in the same cycle still writes data.
//       Upstream must suppress writebacks of squashed instrs.
//   - Issue_En while Issue_Ready=0: ignored (no count change). Issue_Ready is purely combinational on pend[Issue_RD].
//   - Busy: REG_R_Busy[p] = (eff_pend[REG_R_Addr[p]] != 0) & addr!=0, where eff_pend is defined under CONFIGURATION.
//     Issue this cycle does not affect Busy until the next cycle.
//   - Reads are combinational; latency 0 (plus forwarding, see CONFIGURATION).
//   - All read ports are independent; duplicate addresses return identical data and Busy.
// CONFIGURATION
//   REGFILE_WB_BYPASS_EN
//   - Defined:
//     - A same-cycle writeback to a read address (addr!=0) forwards REG_W_Data to REG_R_Data.
//     - eff_pend = pend minus 1 (floor 0) for the writeback reg, so Busy and Stall_D drop in the writeback cycle.
//   - Undefined:
//     - Reads return stored regs and eff_pend = pend.
//     - Written data becomes visible, and Busy clears, on the cycle after writeback (one extra stall cycle per RAW).
// TESTING
//   1 Reset: RST=1 one cycle -> all ports read 0, REG_R_Busy=0, Stall_D=0, Issue_Ready=1.
//   2 Issue rd=5, next cycle read x5 with Used=1 -> Busy=1, Stall_D=1.
//     Then writeback x5=0xDEADBEEF:
//     - BYPASS_EN: Data=0xDEADBEEF and Stall_D=0 in the same cycle.
//     - Without: both change the following cycle.
//   3 Issue rd=7 three times (PEND_W=2) -> Issue_Ready=0.
//     4th issue ignored; three writebacks -> Busy clears only after the third.
//   4 Issue rd=3 and writeback x3 in the same cycle with pend=1 -> pend stays 1, Busy still 1.
//   5 pend[9]=2, Flush_En=1 with Issue_En rd=9 -> pend[9]=0 next cycle.
//     A later writeback x9=0x1234 writes data and Busy stays 0.
//   6 Writeback x0=0xFFFFFFFF and issue rd=0 -> x0 reads 0, Busy=0.
//     RST asserted mid-writeback of x4 -> x4 reads 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with a per-register pending-write scoreboard for decode-stage RAW stalls.
// Optional macro REGFILE_WB_BYPASS_EN forwards same-cycle writeback data and busy-release to the read ports.

module regfile_sb_entry #(
  parameter int XLEN   = 32,
  parameter int PEND_W = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_hit_i,
  input  logic              iss_hit_i,
  input  logic              flush_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN-1:0]   data_o,
  output logic [PEND_W-1:0] pend_o
);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [XLEN-1:0]   data_q, data_d;
  logic [PEND_W-1:0] pend_q, pend_d;

  // iss_hit_i is only raised below the max count, so the increment never wraps
  always_comb begin
    data_d = data_q;
    pend_d = pend_q;
    if (wr_hit_i) data_d = wdata_i;
    if (flush_i)
      pend_d = '0;
    else if (iss_hit_i && !wr_hit_i)
      pend_d = pend_q + PEND_ONE;
    else if (wr_hit_i && !iss_hit_i && pend_q != '0)
      pend_d = pend_q - PEND_ONE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q <= '0;
      pend_q <= '0;
    end else begin
      data_q <= data_d;
      pend_q <= pend_d;
    end
  end

  assign data_o = data_q;
  assign pend_o = pend_q;
endmodule

module regfile_rd_port #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int PEND_W   = 2,
  parameter int ADDR_W   = 5,
  parameter bit BYPASS   = 1'b0
) (
  input  logic [ADDR_W-1:0]                 addr_i,
  input  logic                              used_i,
  input  logic [NUM_REGS-1:0][XLEN-1:0]     regs_i,
  input  logic [NUM_REGS-1:0][PEND_W-1:0]   pend_i,
  input  logic                              w_en_i,
  input  logic [ADDR_W-1:0]                 w_addr_i,
  input  logic [XLEN-1:0]                   w_data_i,
  output logic [XLEN-1:0]                   data_o,
  output logic                              busy_o,
  output logic                              stall_o
);
  logic              fwd;
  logic              dec;
  logic [PEND_W-1:0] pend_rd;
  logic [PEND_W-1:0] eff_pend;

  assign fwd      = BYPASS && w_en_i && (w_addr_i == addr_i) && (addr_i != '0);
  assign pend_rd  = pend_i[addr_i];
  // a retiring writeback releases one pending slot early when forwarding
  assign dec      = fwd && (pend_rd != '0);
  assign eff_pend = pend_rd - PEND_W'(dec);

  assign data_o  = (addr_i == '0) ? '0 : (fwd ? w_data_i : regs_i[addr_i]);
  assign busy_o  = (addr_i != '0) && (eff_pend != '0);
  assign stall_o = used_i && busy_o;
endmodule

module regfile_scoreboard #(
  parameter int XLEN        = 32,
  parameter int NUM_REGS    = 32,
  parameter int NUM_R_PORTS = 2,
  parameter int PEND_W      = 2
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic [NUM_R_PORTS*$clog2(NUM_REGS)-1:0] REG_R_Addr,
  input  logic [NUM_R_PORTS-1:0]                REG_R_Used,
  output logic [NUM_R_PORTS*XLEN-1:0]           REG_R_Data,
  output logic [NUM_R_PORTS-1:0]                REG_R_Busy,
  output logic                                  Stall_D,
  input  logic                                  Issue_En,
  input  logic [$clog2(NUM_REGS)-1:0]           Issue_RD,
  output logic                                  Issue_Ready,
  input  logic                                  REG_W_En,
  input  logic [$clog2(NUM_REGS)-1:0]           REG_W_Addr,
  input  logic [XLEN-1:0]                       REG_W_Data,
  input  logic                                  Flush_En
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [NUM_REGS-1:0][XLEN-1:0]   regs;
  logic [NUM_REGS-1:0][PEND_W-1:0] pend;
  logic [NUM_R_PORTS-1:0]          stall_vec;
  logic                            iss_vld;

  assign regs[0] = '0;
  assign pend[0] = '0;

  assign Issue_Ready = (Issue_RD == '0) || (pend[Issue_RD] != PEND_MAX);
  // a flush squashes the issuing instruction too
  assign iss_vld     = Issue_En && Issue_Ready && !Flush_En && (Issue_RD != '0);

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    regfile_sb_entry #(.XLEN(XLEN), .PEND_W(PEND_W)) u_entry (
      .CLK       (CLK),
      .RST       (RST),
      .wr_hit_i  (REG_W_En && (REG_W_Addr == ADDR_W'(r))),
      .iss_hit_i (iss_vld && (Issue_RD == ADDR_W'(r))),
      .flush_i   (Flush_En),
      .wdata_i   (REG_W_Data),
      .data_o    (regs[r]),
      .pend_o    (pend[r])
    );
  end

  for (genvar p = 0; p < NUM_R_PORTS; p++) begin : g_rd
    regfile_rd_port #(
      .XLEN(XLEN), .NUM_REGS(NUM_REGS), .PEND_W(PEND_W),
      .ADDR_W(ADDR_W), .BYPASS(BYPASS)
    ) u_port (
      .addr_i   (REG_R_Addr[p*ADDR_W +: ADDR_W]),
      .used_i   (REG_R_Used[p]),
      .regs_i   (regs),
      .pend_i   (pend),
      .w_en_i   (REG_W_En),
      .w_addr_i (REG_W_Addr),
      .w_data_i (REG_W_Data),
      .data_o   (REG_R_Data[p*XLEN +: XLEN]),
      .busy_o   (REG_R_Busy[p]),
      .stall_o  (stall_vec[p])
    );
  end

  assign Stall_D = |stall_vec;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised and directed bench for regfile_scoreboard against a behavioural scoreboard model.
module tb_regfile_scoreboard;
  localparam int XLEN = 32, NREGS = 32, NR = 2, PEND_W = 2, AW = 5;
  localparam int PMAX = (1 << PEND_W) - 1;
`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [NR*AW-1:0]     REG_R_Addr;
  logic [NR-1:0]        REG_R_Used;
  logic [NR*XLEN-1:0]   REG_R_Data;
  logic [NR-1:0]        REG_R_Busy;
  logic                 Stall_D;
  logic                 Issue_En;
  logic [AW-1:0]        Issue_RD;
  logic                 Issue_Ready;
  logic                 REG_W_En;
  logic [AW-1:0]        REG_W_Addr;
  logic [XLEN-1:0]      REG_W_Data;
  logic                 Flush_En;

  int vectors = 0, miscompares = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  int              m_pend [NREGS];

  regfile_scoreboard #(.XLEN(XLEN), .NUM_REGS(NREGS), .NUM_R_PORTS(NR), .PEND_W(PEND_W)) dut (
    .CLK(CLK), .RST(RST), .REG_R_Addr(REG_R_Addr), .REG_R_Used(REG_R_Used),
    .REG_R_Data(REG_R_Data), .REG_R_Busy(REG_R_Busy), .Stall_D(Stall_D),
    .Issue_En(Issue_En), .Issue_RD(Issue_RD), .Issue_Ready(Issue_Ready),
    .REG_W_En(REG_W_En), .REG_W_Addr(REG_W_Addr), .REG_W_Data(REG_W_Data),
    .Flush_En(Flush_En)
  );

  always #5 CLK = ~CLK;

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (BYP && REG_W_En && REG_W_Addr == a) return REG_W_Data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    int e = m_pend[a];
    if (BYP && REG_W_En && REG_W_Addr == a && e > 0) e--;
    return (a != 0) && (e != 0);
  endfunction

  function automatic logic exp_ready();
    return (Issue_RD == 0) || (m_pend[Issue_RD] < PMAX);
  endfunction

  task automatic idle();
    RST = 0; Issue_En = 0; Issue_RD = '0; REG_W_En = 0; REG_W_Addr = '0;
    REG_W_Data = '0; Flush_En = 0; REG_R_Used = '0; REG_R_Addr = '0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    REG_R_Addr[p*AW +: AW] = a;
  endtask

  // advance one clock, applying the architectural update to the model
  task automatic tick();
    bit rdy;
    @(posedge CLK);
    if (RST) begin
      for (int i = 0; i < NREGS; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
    end else begin
      rdy = exp_ready();
      if (REG_W_En && REG_W_Addr != 0) m_regs[REG_W_Addr] = REG_W_Data;
      if (Flush_En) begin
        for (int i = 0; i < NREGS; i++) m_pend[i] = 0;
      end else begin
        if (Issue_En && rdy && Issue_RD != 0) m_pend[Issue_RD]++;
        if (REG_W_En && REG_W_Addr != 0 && m_pend[REG_W_Addr] > 0) m_pend[REG_W_Addr]--;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    RST = 1; REG_W_En = 1; REG_W_Addr = 5'd4; REG_W_Data = 32'h1111_2222;
    Issue_En = 1; Issue_RD = 5'd4;
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      set_rd(0, AW'($urandom_range(0, NREGS-1)));
      set_rd(1, AW'($urandom_range(0, NREGS-1)));
      REG_R_Used = 2'b11; Issue_RD = AW'($urandom_range(0, NREGS-1));
      #1;
      for (int p = 0; p < NR; p++) begin
        vectors++;
        if (REG_R_Data[p*XLEN +: XLEN] !== '0 || REG_R_Busy[p] !== 1'b0) begin
          miscompares++;
          $display("FAIL reset_port%0d data=%h busy=%b expected 0/0", p, REG_R_Data[p*XLEN +: XLEN], REG_R_Busy[p]);
        end
      end
      vectors++;
      if (Stall_D !== 1'b0 || Issue_Ready !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_ctl stall=%b ready=%b expected 0/1", Stall_D, Issue_Ready);
      end
    end
  endtask

  task automatic test_raw_stall();
    idle(); Issue_En = 1; Issue_RD = 5'd5;
    tick();
    idle(); set_rd(0, 5'd5); REG_R_Used = 2'b01;
    #1; vectors++;
    if (REG_R_Busy[0] !== 1'b1 || Stall_D !== 1'b1) begin
      miscompares++;
      $display("FAIL raw_pending busy=%b stall=%b expected 1/1", REG_R_Busy[0], Stall_D);
    end
    tick();
    REG_W_En = 1; REG_W_Addr = 5'd5; REG_W_Data = 32'hDEADBEEF;
    #1; vectors++;
    if (REG_R_Data[XLEN-1:0] !== (BYP ? 32'hDEADBEEF : 32'h0) || Stall_D !== !BYP) begin
      miscompares++;
      $display("FAIL raw_wb_cycle data=%h stall=%b expected %h/%b", REG_R_Data[XLEN-1:0], Stall_D,
               BYP ? 32'hDEADBEEF : 32'h0, !BYP);
    end
    tick();
    REG_W_En = 0;
    #1; vectors++;
    if (REG_R_Data[XLEN-1:0] !== 32'hDEADBEEF || Stall_D !== 1'b0 || REG_R_Busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL raw_after_wb data=%h stall=%b busy=%b expected deadbeef/0/0", REG_R_Data[XLEN-1:0], Stall_D, REG_R_Busy[0]);
    end
  endtask

  task automatic test_saturate();
    logic [XLEN-1:0] wd;
    idle(); Issue_RD = 5'd7;
    for (int i = 0; i < PMAX; i++) begin
      Issue_En = 1; #1; vectors++;
      if (Issue_Ready !== 1'b1) begin
        miscompares++; $display("FAIL sat_ready_%0d ready=%b expected 1", i, Issue_Ready);
      end
      tick();
    end
    #1; vectors++;
    if (Issue_Ready !== 1'b0) begin
      miscompares++; $display("FAIL sat_full ready=%b expected 0", Issue_Ready);
    end
    tick();
    idle(); set_rd(1, 5'd7); REG_R_Used = 2'b10;
    for (int i = 0; i < PMAX; i++) begin
      REG_W_En = 0; #1; vectors++;
      if (REG_R_Busy[1] !== 1'b1) begin
        miscompares++; $display("FAIL sat_busy_pre%0d busy=%b expected 1", i, REG_R_Busy[1]);
      end
      wd = $urandom; REG_W_En = 1; REG_W_Addr = 5'd7; REG_W_Data = wd;
      #1; vectors++;
      if (REG_R_Busy[1] !== !(BYP && i == PMAX-1)) begin
        miscompares++; $display("FAIL sat_busy_wb%0d busy=%b expected %b", i, REG_R_Busy[1], !(BYP && i == PMAX-1));
      end
      tick();
    end
    REG_W_En = 0; Issue_RD = 5'd7;
    #1; vectors++;
    if (REG_R_Busy[1] !== 1'b0 || Issue_Ready !== 1'b1 || REG_R_Data[2*XLEN-1:XLEN] !== wd) begin
      miscompares++;
      $display("FAIL sat_drained busy=%b ready=%b data=%h expected 0/1/%h", REG_R_Busy[1], Issue_Ready, REG_R_Data[2*XLEN-1:XLEN], wd);
    end
  endtask

  task automatic test_issue_wb_same();
    idle(); Issue_En = 1; Issue_RD = 5'd3;
    tick();
    REG_W_En = 1; REG_W_Addr = 5'd3; REG_W_Data = 32'h0000_0303;
    tick();
    idle(); set_rd(0, 5'd3);
    #1; vectors++;
    if (REG_R_Busy[0] !== 1'b1 || REG_R_Data[XLEN-1:0] !== 32'h0000_0303) begin
      miscompares++; $display("FAIL same_cycle busy=%b data=%h expected 1/00000303", REG_R_Busy[0], REG_R_Data[XLEN-1:0]);
    end
    REG_W_En = 1; REG_W_Addr = 5'd3; REG_W_Data = 32'h0000_0304;
    tick();
    REG_W_En = 0;
    #1; vectors++;
    if (REG_R_Busy[0] !== 1'b0) begin
      miscompares++; $display("FAIL same_cycle_clear busy=%b expected 0", REG_R_Busy[0]);
    end
  endtask

  task automatic test_flush();
    idle(); Issue_En = 1; Issue_RD = 5'd9;
    tick(); tick();
    Flush_En = 1;
    tick();
    idle(); set_rd(0, 5'd9); set_rd(1, 5'd9); REG_R_Used = 2'b11;
    #1; vectors++;
    if (REG_R_Busy !== 2'b00 || Stall_D !== 1'b0) begin
      miscompares++; $display("FAIL flush_clear busy=%b stall=%b expected 00/0", REG_R_Busy, Stall_D);
    end
    REG_W_En = 1; REG_W_Addr = 5'd9; REG_W_Data = 32'h1234;
    tick();
    REG_W_En = 0; Issue_RD = 5'd9;
    #1; vectors++;
    if (REG_R_Data[XLEN-1:0] !== 32'h1234 || REG_R_Data[2*XLEN-1:XLEN] !== 32'h1234 || REG_R_Busy !== 2'b00) begin
      miscompares++; $display("FAIL flush_late_wb data=%h busy=%b expected 1234/00", REG_R_Data[XLEN-1:0], REG_R_Busy);
    end
  endtask

  task automatic test_x0_and_reset();
    idle(); REG_W_En = 1; REG_W_Addr = '0; REG_W_Data = 32'hFFFFFFFF;
    Issue_En = 1; Issue_RD = '0; REG_R_Used = 2'b11;
    #1; vectors++;
    if (Issue_Ready !== 1'b1 || REG_R_Data !== '0 || REG_R_Busy !== 2'b00) begin
      miscompares++; $display("FAIL x0_wb ready=%b data=%h busy=%b expected 1/0/00", Issue_Ready, REG_R_Data, REG_R_Busy);
    end
    tick();
    idle(); REG_R_Used = 2'b11;
    #1; vectors++;
    if (REG_R_Data !== '0 || REG_R_Busy !== 2'b00 || Stall_D !== 1'b0) begin
      miscompares++; $display("FAIL x0_after data=%h busy=%b stall=%b expected 0/00/0", REG_R_Data, REG_R_Busy, Stall_D);
    end
    REG_W_En = 1; REG_W_Addr = 5'd4; REG_W_Data = 32'hAAAA_5555;
    tick();
    REG_W_En = 0; set_rd(0, 5'd4);
    #1; vectors++;
    if (REG_R_Data[XLEN-1:0] !== 32'hAAAA_5555) begin
      miscompares++; $display("FAIL x4_write data=%h expected aaaa5555", REG_R_Data[XLEN-1:0]);
    end
    RST = 1; REG_W_En = 1; REG_W_Addr = 5'd4; REG_W_Data = 32'h5555_AAAA;
    tick();
    idle(); set_rd(0, 5'd4);
    #1; vectors++;
    if (REG_R_Data[XLEN-1:0] !== '0) begin
      miscompares++; $display("FAIL rst_mid_wb data=%h expected 0", REG_R_Data[XLEN-1:0]);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int c = 0; c < 400; c++) begin
      idle();
      RST = ($urandom_range(0, 99) == 0);
      Flush_En = ($urandom_range(0, 39) == 0);
      Issue_En = $urandom_range(0, 1);
      Issue_RD = AW'($urandom_range(0, 7));
      REG_W_En = $urandom_range(0, 1);
      REG_W_Addr = AW'($urandom_range(0, 7));
      REG_W_Data = $urandom;
      REG_R_Used = NR'($urandom);
      for (int p = 0; p < NR; p++)
        set_rd(p, ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7)));
      #1;
      for (int p = 0; p < NR; p++) begin
        a = REG_R_Addr[p*AW +: AW];
        vectors++;
        if (REG_R_Data[p*XLEN +: XLEN] !== exp_data(a) || REG_R_Busy[p] !== exp_busy(a)) begin
          miscompares++;
          $display("FAIL rand_c%0d_p%0d addr=%0d data=%h busy=%b expected %h/%b", c, p, a,
                   REG_R_Data[p*XLEN +: XLEN], REG_R_Busy[p], exp_data(a), exp_busy(a));
        end
      end
      vectors++;
      if (Stall_D !== ((REG_R_Used[0] & exp_busy(REG_R_Addr[0 +: AW])) | (REG_R_Used[1] & exp_busy(REG_R_Addr[AW +: AW])))
          || Issue_Ready !== exp_ready()) begin
        miscompares++;
        $display("FAIL rand_c%0d_ctl stall=%b ready=%b expected ready=%b", c, Stall_D, Issue_Ready, exp_ready());
      end
      tick();
    end
  endtask

  initial begin
    idle(); RST = 1;
    @(negedge CLK);
    test_reset();
    test_raw_stall();
    test_saturate();
    test_issue_wb_same();
    test_flush();
    test_x0_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
